// File: rtl/pacman_mover.sv
// Avalon-MM write master that steps Pac-Man's position once per FRAME_DIV frames
// and pushes X (addr 0) then Y (addr 1) to the sprite peripheral. Optional PACMAN_WRAP_EN enables the horizontal tunnel wrap.
module pacman_mover #(
    parameter int X_INIT    = 340,
    parameter int Y_INIT    = 240,
    parameter int X_MIN     = 104,
    parameter int X_MAX     = 520,
    parameter int Y_MIN     = 104,
    parameter int Y_MAX     = 352,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_vs,
    input  logic [3:0]  btn,
    output logic [2:0]  avm_address,
    output logic [15:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_chipselect,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WR_X, S_WR_Y} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    function automatic logic [9:0] clamp_axis(input logic [10:0] v,
                                              input logic [10:0] lo,
                                              input logic [10:0] hi);
        if (v < lo)      return lo[9:0];
        else if (v > hi) return hi[9:0];
        else             return v[9:0];
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    dir_t        r_dir;
    logic        r_vs_d;
    logic [7:0]  r_fcnt;
    logic [9:0]  r_pos_x;
    logic [9:0]  r_pos_y;
    logic [7:0]  r_overrun;
    logic [2:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_write;
    logic        r_busy;

    logic        w_tick;
    logic        w_event;
    logic        w_moved;
    logic        w_accept;
    logic [10:0] w_cand_x;
    logic [10:0] w_cand_y;
    logic [9:0]  w_nxt_x;
    logic [9:0]  w_nxt_y;
    logic [9:0]  w_px_upd;
    logic [9:0]  w_py_upd;
    logic [2:0]  w_addr_nxt;
    logic [15:0] w_wdata_nxt;
    logic        w_write_nxt;

    assign w_tick  = r_vs_d & ~vga_vs;
    assign w_event = w_tick & (r_fcnt == 8'(FRAME_DIV - 1));

    // Latch the highest-priority pressed direction; no press keeps the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_dir <= DIR_NONE;
        else if (btn[3]) r_dir <= DIR_UP;
        else if (btn[2]) r_dir <= DIR_DOWN;
        else if (btn[1]) r_dir <= DIR_LEFT;
        else if (btn[0]) r_dir <= DIR_RIGHT;
        else             r_dir <= r_dir;
    end

    // Vsync edge detector and frame divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_d <= 1'b1;
            r_fcnt <= 8'd0;
        end else begin
            r_vs_d <= vga_vs;
            if (w_event)     r_fcnt <= 8'd0;
            else if (w_tick) r_fcnt <= r_fcnt + 8'd1;
            else             r_fcnt <= r_fcnt;
        end
    end

    // Candidate position one step along cur_dir, clamped (or wrapped on X) into the maze.
    always_comb begin
        w_cand_x = {1'b0, r_pos_x};
        w_cand_y = {1'b0, r_pos_y};
        case (r_dir)
            DIR_UP:    w_cand_y = {1'b0, r_pos_y} - 11'(STEP);
            DIR_DOWN:  w_cand_y = {1'b0, r_pos_y} + 11'(STEP);
            DIR_LEFT:  w_cand_x = {1'b0, r_pos_x} - 11'(STEP);
            DIR_RIGHT: w_cand_x = {1'b0, r_pos_x} + 11'(STEP);
            default:   w_cand_x = {1'b0, r_pos_x};
        endcase
`ifdef PACMAN_WRAP_EN
        if (r_dir == DIR_LEFT && w_cand_x < 11'(X_MIN))
            w_nxt_x = 10'(X_MAX);
        else if (r_dir == DIR_RIGHT && w_cand_x > 11'(X_MAX))
            w_nxt_x = 10'(X_MIN);
        else
            w_nxt_x = clamp_axis(w_cand_x, 11'(X_MIN), 11'(X_MAX));
`else
        w_nxt_x = clamp_axis(w_cand_x, 11'(X_MIN), 11'(X_MAX));
`endif
        w_nxt_y = clamp_axis(w_cand_y, 11'(Y_MIN), 11'(Y_MAX));
        w_moved = (w_nxt_x != r_pos_x) || (w_nxt_y != r_pos_y);
    end

    // Next-state logic; a move is only accepted from IDLE when it changes the position.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_event && w_moved) begin
                    w_state_nxt = S_WR_X;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_X:  w_state_nxt = avm_waitrequest ? S_WR_X : S_WR_Y;
            S_WR_Y:  w_state_nxt = avm_waitrequest ? S_WR_Y : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_px_upd = w_accept ? w_nxt_x : r_pos_x;
    assign w_py_upd = w_accept ? w_nxt_y : r_pos_y;

    // Bus outputs are decoded from the next state so they can be registered without a cycle of lag.
    always_comb begin
        w_write_nxt = 1'b0;
        w_addr_nxt  = 3'd0;
        w_wdata_nxt = 16'd0;
        case (w_state_nxt)
            S_WR_X: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = 3'd0;
                w_wdata_nxt = {6'b000000, w_px_upd};
            end
            S_WR_Y: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = 3'd1;
                w_wdata_nxt = {6'b000000, w_py_upd};
            end
            default: begin
                w_write_nxt = 1'b0;
                w_addr_nxt  = 3'd0;
                w_wdata_nxt = 16'd0;
            end
        endcase
    end

    // State, position, bus and overrun registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pos_x   <= 10'(X_INIT);
            r_pos_y   <= 10'(Y_INIT);
            r_write   <= 1'b0;
            r_addr    <= 3'd0;
            r_wdata   <= 16'd0;
            r_busy    <= 1'b0;
            r_overrun <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pos_x <= w_px_upd;
            r_pos_y <= w_py_upd;
            r_write <= w_write_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_event && (r_state != S_IDLE) && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;
            else
                r_overrun <= r_overrun;
        end
    end

    assign avm_address    = r_addr;
    assign avm_writedata  = r_wdata;
    assign avm_write      = r_write;
    assign avm_chipselect = r_write;
    assign busy           = r_busy;
    assign pos_x          = r_pos_x;
    assign pos_y          = r_pos_y;
    assign overrun_cnt    = r_overrun;

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: one instance with FRAME_DIV=1, one with FRAME_DIV=3.
module tb_pacman_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs1, vs3, wait1;
    logic [3:0]  btn1, btn3;
    logic [2:0]  addr1, addr3;
    logic [15:0] wdata1, wdata3;
    logic        wr1, wr3, cs1, cs3, busy1, busy3;
    logic [9:0]  px1, py1, px3, py3;
    logic [7:0]  ovr1, ovr3;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xbeats;

    always #5 clk = ~clk;

    pacman_mover u_dut1 (
        .clk(clk), .reset(rst), .vga_vs(vs1), .btn(btn1),
        .avm_address(addr1), .avm_writedata(wdata1), .avm_write(wr1),
        .avm_chipselect(cs1), .avm_waitrequest(wait1), .busy(busy1),
        .pos_x(px1), .pos_y(py1), .overrun_cnt(ovr1)
    );

    pacman_mover #(.FRAME_DIV(3)) u_dut3 (
        .clk(clk), .reset(rst), .vga_vs(vs3), .btn(btn3),
        .avm_address(addr3), .avm_writedata(wdata3), .avm_write(wr3),
        .avm_chipselect(cs3), .avm_waitrequest(1'b0), .busy(busy3),
        .pos_x(px3), .pos_y(py3), .overrun_cnt(ovr3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame_tick(input bit use3);
        @(posedge clk); #1;
        if (use3) vs3 = 1'b0; else vs1 = 1'b0;
        @(posedge clk); #1;
        if (use3) vs3 = 1'b1; else vs1 = 1'b1;
    endtask

    task automatic press1(input logic [3:0] b);
        @(posedge clk); #1 btn1 = b;
        @(posedge clk); #1 btn1 = 4'b0000;
    endtask

    task automatic check_beat1(input string tag, input logic [2:0] a, input logic [15:0] d);
        check_val({tag, "_wr"},   32'(wr1),    32'd1);
        check_val({tag, "_cs"},   32'(cs1),    32'd1);
        check_val({tag, "_busy"}, 32'(busy1),  32'd1);
        check_val({tag, "_addr"}, 32'(addr1),  32'(a));
        check_val({tag, "_data"}, 32'(wdata1), 32'(d));
    endtask

    initial begin
        rst = 1'b1; vs1 = 1'b1; vs3 = 1'b1; wait1 = 1'b0;
        btn1 = 4'b0000; btn3 = 4'b0000;
        #23 rst = 1'b0;
        @(negedge clk);
        check_val("rst_px", 32'(px1), 32'd340);
        check_val("rst_py", 32'(py1), 32'd240);
        check_val("rst_wr", 32'(wr1), 32'd0);
        check_val("rst_busy", 32'(busy1), 32'd0);
        check_val("rst_ovr", 32'(ovr1), 32'd0);
        check_val("rst_data", 32'(wdata1), 32'd0);

        // RIGHT for one cycle, then a frame tick
        press1(4'b0001);
        frame_tick(1'b0);
        @(negedge clk); check_beat1("t1_x", 3'd0, 16'd341);
        check_val("t1_px", 32'(px1), 32'd341);
        @(negedge clk); check_beat1("t1_y", 3'd1, 16'd240);
        @(negedge clk);
        check_val("t1_idle_wr", 32'(wr1), 32'd0);
        check_val("t1_idle_busy", 32'(busy1), 32'd0);
        check_val("t1_idle_data", 32'(wdata1), 32'd0);

        // up+down together: UP wins
        press1(4'b1100);
        frame_tick(1'b0);
        @(negedge clk); check_beat1("t2_x", 3'd0, 16'd341);
        @(negedge clk); check_beat1("t2_y", 3'd1, 16'd239);
        @(negedge clk); check_val("t2_idle_wr", 32'(wr1), 32'd0);

        // 3-cycle stall in WR_X with a frame tick during the stall
        wait1 = 1'b1;
        frame_tick(1'b0);
        @(negedge clk); check_beat1("t3_s0", 3'd0, 16'd341);
        @(posedge clk); #1 vs1 = 1'b0;
        @(negedge clk); check_beat1("t3_s1", 3'd0, 16'd341);
        @(posedge clk); #1 vs1 = 1'b1;
        @(negedge clk); check_beat1("t3_s2", 3'd0, 16'd341);
        check_val("t3_ovr", 32'(ovr1), 32'd1);
        check_val("t3_py", 32'(py1), 32'd238);
        check_val("t3_px", 32'(px1), 32'd341);
        @(posedge clk); #1 wait1 = 1'b0;
        @(negedge clk); check_beat1("t3_s3", 3'd0, 16'd341);
        @(negedge clk); check_beat1("t3_y", 3'd1, 16'd238);
        @(negedge clk); check_val("t3_idle_wr", 32'(wr1), 32'd0);

        // walk LEFT to the X_MIN wall, then push into it
        press1(4'b0010);
        for (int i = 0; i < 237; i++) begin
            frame_tick(1'b0);
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        check_val("t4_px_min", 32'(px1), 32'd104);
        check_val("t4_py", 32'(py1), 32'd238);
        frame_tick(1'b0);
        @(negedge clk);
`ifdef PACMAN_WRAP_EN
        check_beat1("t4_wrap", 3'd0, 16'd520);
        check_val("t4_px_wrap", 32'(px1), 32'd520);
`else
        check_val("t4_wall_wr", 32'(wr1), 32'd0);
        check_val("t4_wall_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        check_val("t4_wall_wr2", 32'(wr1), 32'd0);
        check_val("t4_wall_px", 32'(px1), 32'd104);
`endif

        // FRAME_DIV=3 instance: RIGHT held, six ticks
        btn3 = 4'b0001;
        n_xbeats = 0;
        for (int i = 0; i < 5; i++) begin
            frame_tick(1'b1);
            @(negedge clk);
            check_val($sformatf("t5_wr_tick%0d", i + 1), 32'(wr3), 32'(i == 2));
            if (wr3 && addr3 == 3'd0) n_xbeats++;
            repeat (2) @(posedge clk);
        end
        check_val("t5_px_mid", 32'(px3), 32'd341);
        frame_tick(1'b1);
        @(negedge clk);
        check_val("t5_wr_tick6", 32'(wr3), 32'd1);
        check_val("t5_data6", 32'(wdata3), 32'd342);
        if (wr3 && addr3 == 3'd0) n_xbeats++;
        check_val("t5_xbeats", 32'(n_xbeats), 32'd2);
        check_val("t5_px", 32'(px3), 32'd342);
        #1 rst = 1'b1;
        #1;
        check_val("t5_rst_wr", 32'(wr3), 32'd0);
        check_val("t5_rst_cs", 32'(cs3), 32'd0);
        check_val("t5_rst_busy", 32'(busy3), 32'd0);
        check_val("t5_rst_px", 32'(px3), 32'd340);
        #10 rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pacman_mover.md
# pacman_mover

Avalon-MM write master that owns Pac-Man's position and drives it into the VGA sprite peripheral's position registers. Once per N video frames it samples the latched joystick direction, steps the position by a fixed amount inside the maze bounds, and issues two register writes: X to address 0, then Y to address 1. It sits between the button/GPIO inputs and the display peripheral's slave port, and replaces software-driven position writes.

## Interface
Parameters:
- X_INIT, 340: reset X; equals the display's reset X.
- Y_INIT, 240: reset Y; equals the display's reset Y.
- X_MIN, 104 / X_MAX, 520: inclusive X bounds, in pixels.
- Y_MIN, 104 / Y_MAX, 352: inclusive Y bounds, in pixels.
- STEP, 1: pixels moved per move event, 1–15.
- FRAME_DIV, 1: frames per move event, 1–255.

Ports:
- clk  in  1  system clock (50 MHz, same clock as the display).
- reset  in  1  asynchronous, active-high.
- vga_vs  in  1  active-low vertical sync from the display's counters.
- btn  in  4  {up, down, left, right}, active-high, synchronous to clk.
- avm_address  out  3  register address.
- avm_writedata  out  16  write data.
- avm_write  out  1  write strobe.
- avm_chipselect  out  1  equals avm_write.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high when the FSM is not in IDLE.
- pos_x  out  10  current X.
- pos_y  out  10  current Y.
- overrun_cnt  out  8  count of move events dropped while busy; saturates at 255.

## Operation
- Direction register cur_dir ∈ {NONE, UP, DOWN, LEFT, RIGHT}. Reset value is NONE.
  - On each clk edge where btn is nonzero, cur_dir loads the highest-priority pressed button: up > down > left > right.
  - btn == 0 holds cur_dir. Pac-Man keeps moving in the last direction pressed.
- Frame tick: vs_d registers vga_vs; reset value is 1. A tick occurs on an edge where vs_d = 1 and vga_vs = 0.
- Frame counter fcnt: reset value 0, width 8.
  - On a tick with fcnt = FRAME_DIV−1, fcnt returns to 0 and a move event fires.
  - On any other tick, fcnt increments.
- Move event:
  - The event uses cur_dir as it was registered before the event edge.
  - The candidate position is computed in 11-bit arithmetic, so X_MIN − STEP cannot underflow.
  - Each axis clamps to [MIN, MAX].
  - If the clamped position differs from the current position, pos_x and pos_y update and the FSM enters WR_X.
  - If the position is unchanged (including cur_dir = NONE), no state change occurs and no bus traffic is issued.
- Move event while busy: the event is discarded, position is unchanged, and overrun_cnt increments (saturating).
- FSM states: IDLE, WR_X, WR_Y.
  - IDLE: avm_write = 0, avm_address = 0, avm_writedata = 0.
  - WR_X: avm_write = 1, avm_address = 0, avm_writedata = {6'b0, pos_x}.
  - WR_Y: avm_write = 1, avm_address = 1, avm_writedata = {6'b0, pos_y}.
  - WR_X → WR_Y, and WR_Y → IDLE, on a clk edge where avm_waitrequest = 0.
  - While avm_waitrequest = 1, address, data and write hold stable.
- All outputs are driven from registers. There are no combinational paths from inputs to outputs.
- Reset values:
  - pos_x = X_INIT, pos_y = Y_INIT.
  - FSM in IDLE.
  - All avm_* outputs 0, busy = 0, overrun_cnt = 0.
  - No write is issued after reset; the slave already holds the same values.

## Timing
- Tick-to-write latency is one cycle: avm_write rises in the cycle after the first clk edge that samples vga_vs low.
- With avm_waitrequest tied low:
  - avm_write is high for exactly 2 cycles (X, then Y).
  - busy is high for 2 cycles.
- Each waitrequest stall cycle extends the current beat by 1 cycle.
- pos_x and pos_y update on the event edge, so they are valid before the X beat.
- Reset mid-transfer: avm_write drops asynchronously and the sequence is abandoned. The slave holds whatever it last accepted. This is acceptable because the slave is reset by the same signal.
- Button changes on the event edge take effect at the next move event.

## Configuration
- PACMAN_WRAP_EN defined:
  - Horizontal tunnel wrap. A LEFT move from pos_x − STEP < X_MIN sets pos_x = X_MAX.
  - A RIGHT move from pos_x + STEP > X_MAX sets pos_x = X_MIN.
  - The Y axis always clamps.
- PACMAN_WRAP_EN undefined: both axes clamp as described above.

## Test plan
- Reset, then btn = 0001 (right) for 1 cycle, then a vga_vs falling edge, with waitrequest = 0 → one cycle later:
  - write (address 0, data 341) for 1 cycle, then write (address 1, data 240) for 1 cycle.
  - busy high for 2 cycles; pos_x = 341.
- btn = 1100 (up+down) pressed together, FRAME_DIV = 1 → UP wins; the Y write carries 239 and the X write carries the unchanged X.
- Hold waitrequest = 1 for 3 cycles during WR_X → address/data/write stable for 4 cycles; the Y beat follows; a frame tick during the stall increments overrun_cnt to 1 and leaves the position unchanged.
- pos_x = 104, LEFT, STEP = 1:
  - Without PACMAN_WRAP_EN → no bus traffic, pos_x stays 104.
  - With PACMAN_WRAP_EN → X write of 520.
- FRAME_DIV = 3, RIGHT held, 6 ticks → exactly 2 write pairs, pos_x = 342; assert reset during the second WR_X → avm_write low immediately, pos_x = 340.
